// File: rtl/snn_pkg.sv
// ============================================================================
// Module  : snn_pkg
// Brief   : Shared constants and loader FSM state type for the SNN front end.
// Revision: 1.0
// ============================================================================
`default_nettype none

package snn_pkg;

  localparam int NUM_PIX = 784;
  localparam int ADDR_W  = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UNPACK    = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/snn_input_loader.sv
// ============================================================================
// Module  : snn_input_loader
// Brief   : Unpacks UART image bytes into 1-bit input RAM writes, starts the
//           core, then lends the RAM address port to the core until done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snn_input_loader
  import snn_pkg::*;
#(
  parameter int NUM_PIX = snn_pkg::NUM_PIX,
  parameter int ADDR_W  = snn_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_wdata,
  output logic              start,
  output logic              busy,
  output logic              overrun
);

  localparam int NUM_BYTES = NUM_PIX / 8;
  localparam logic [ADDR_W-1:0] C_LAST_PIX = ADDR_W'(NUM_BYTES * 8 - 1);

  loader_state_t     state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    busy_d    = busy_q;
    // Only IDLE can accept a byte; anything arriving elsewhere is lost.
    overrun_d = overrun_q | (rx_rdy && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          shift_d   = rx_data;
          bit_cnt_d = 3'd0;
          busy_d    = 1'b1;
          state_d   = UNPACK;
        end
      end
      UNPACK: begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
        if (bit_cnt_q == 3'd7) begin
          state_d = (pix_cnt_q == C_LAST_PIX) ? START : IDLE;
        end
      end
      START: begin
        pix_cnt_d = '0;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core owns the address port from the start pulse until done.
  assign ram_addr  = ((state_q == START) || (state_q == WAIT_DONE)) ? core_addr : pix_cnt_q;
  assign ram_we    = (state_q == UNPACK);
  assign ram_wdata = shift_q[0];
  assign start     = (state_q == START);
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire
